maxpool_engine: RTL and testbench
=================================

MAXPOOL_ENGINE -- requirements
Module: maxpool_engine

Interface
REQ-001 SHALL have parameters: width 8 (data bits, signed fixed point); memaddrbit 17 (BRAM address bits).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous, active-low reset.
REQ-004 SHALL have port mp_start, input, 1, one-cycle start pulse from controller.
REQ-005 SHALL have port mp_enable, input, 1, run gate; low stalls the engine.
REQ-006 SHALL have config inputs, each memaddrbit wide: mp_dkr, mp_dkc, mp_dr, mp_dc, mp_di, mp_dr_out, mp_dc_out, mp_di_out, mp_inaddr, mp_outaddr; plus mp_step, 3 bits.
REQ-007 SHALL have port mp_memaddr, output, memaddrbit, shared single-port BRAM address.
REQ-008 SHALL have port mp_wea, output, 1, BRAM write enable.
REQ-009 SHALL have port mp_mem_in, output, width, BRAM write data.
REQ-010 SHALL have port mp_mem_out, input, width, BRAM read data; valid 1 cycle after its address.
REQ-011 SHALL have outputs mp_ir_out, mp_ic_out, mp_ii_out, memaddrbit each, carrying the current output coordinates.
REQ-012 SHALL have outputs mp_busy, 1, and mp_picture_finish, 1, a one-cycle done pulse.

Function
REQ-013 SHALL run FSM IDLE -> RD -> DRAIN -> WR -> (RD | DONE) -> IDLE.
REQ-014 SHALL latch all config on mp_start in IDLE; mp_start outside IDLE is ignored.
REQ-015 SHALL use addressing in1 = mp_inaddr + ii*dr*dc + (ir_out*step+ikr)*dc + (ic_out*step+ikc); out = mp_outaddr + ii*dr_out*dc_out + ir_out*dc_out + ic_out; all arithmetic modulo 2^memaddrbit.
REQ-016 SHALL iterate ii outermost, then ir_out, then ic_out; inside each window, ikr outer and ikc inner.
REQ-017 RD SHALL issue one read per kernel element, one per cycle, for dkr*dkc cycles; DRAIN SHALL capture the last datum; WR SHALL assert mp_wea for exactly 1 cycle with the out address. Each window therefore takes dkr*dkc+2 cycles.
REQ-018 SHALL hold a running max, initialised to 8'h80 (-128) at window start, and update it with a signed compare of mp_mem_out on each cycle following a read.
REQ-019 SHALL skip any element with row >= dr or col >= dc: no address is issued, the max is not updated, and the cycle is still consumed, so the cycle count is constant.
REQ-020 SHALL, when mp_enable is low, issue no new read, hold all counters and the FSM, and force mp_wea to 0. A datum already in flight SHALL still be captured.
REQ-021 SHALL pulse mp_picture_finish in DONE, one cycle after the final WR, and keep mp_busy high from the cycle after start through DONE.
REQ-022 SHALL, if any of dkr, dkc, dr_out, dc_out, di_out is zero, go IDLE -> DONE with no BRAM writes.
REQ-023 SHALL drive mp_memaddr to 0 whenever no access is made (IDLE, DRAIN, DONE, skipped elements).

Reset
REQ-024 SHALL, on rst low, immediately force IDLE; all counters, mp_memaddr, mp_mem_in, the running max (8'h80), mp_wea, mp_busy and mp_picture_finish go to 0. This holds mid-operation; a partial result is never written.

Structure
REQ-025 SHALL place the FSM state encodings and the max-init constant 8'h80 in a shared package with the controller.
REQ-026 SHALL place the address generator in one sub-module, maxpool_addrgen, holding the nested counters and address arithmetic.

Verification
REQ-027 Case 12x12x8, 2x2 kernel, step 2, out 6x6x8, inaddr 1061, outaddr 2213 -> 288 writes, the first to address 2213 as the max of addresses 1061/1062/1073/1074; finish pulse 1729 cycles after start.
REQ-028 Window values -5, -3, -128, -7 -> writes -3 (8'hFD).
REQ-029 Case dr=dc=5, dkr=dkc=2, step 2, out 3x3x1 -> last window reads only address inaddr+24; the written value equals that datum; 54 cycles.
REQ-030 mp_enable low for 10 cycles mid-window -> the same writes and values as an unstalled run; finish is delayed by exactly 10 cycles.
REQ-031 rst low during write 100 -> all outputs 0 at once; a restart then completes 288 writes.
REQ-032 mp_start re-pulsed while busy -> ignored; counts unchanged.

Source files
------------

// File: rtl/maxpool_engine_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | maxpool_engine_pkg : FSM state encoding and running-max seed |
// | rev 1.0                                                      |
// +--------------------------------------------------------------+
package maxpool_engine_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_DRAIN = 3'd2,
    S_WR    = 3'd3,
    S_DONE  = 3'd4
  } mp_state_t;

  localparam logic signed [7:0] c_MAX_INIT = 8'sh80;

endpackage
`default_nettype wire

// File: rtl/maxpool_engine_addrgen.sv
`default_nettype none
// +--------------------------------------------------------------+
// | maxpool_addrgen : window/kernel counters and BRAM addressing |
// | rev 1.0                                                      |
// +--------------------------------------------------------------+
module maxpool_addrgen #(
  parameter int MEMADDRBIT = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MEMADDRBIT-1:0] i_dkr,
  input  logic [MEMADDRBIT-1:0] i_dkc,
  input  logic [MEMADDRBIT-1:0] i_dr,
  input  logic [MEMADDRBIT-1:0] i_dc,
  input  logic [MEMADDRBIT-1:0] i_di,
  input  logic [MEMADDRBIT-1:0] i_dr_out,
  input  logic [MEMADDRBIT-1:0] i_dc_out,
  input  logic [MEMADDRBIT-1:0] i_di_out,
  input  logic [MEMADDRBIT-1:0] i_inaddr,
  input  logic [MEMADDRBIT-1:0] i_outaddr,
  input  logic [2:0]            i_step,
  input  logic                  i_clear,
  input  logic                  i_k_adv,
  input  logic                  i_w_adv,
  output logic                  o_k_last,
  output logic                  o_w_last,
  output logic                  o_elem_valid,
  output logic [MEMADDRBIT-1:0] o_in_addr,
  output logic [MEMADDRBIT-1:0] o_out_addr,
  output logic [MEMADDRBIT-1:0] o_ii,
  output logic [MEMADDRBIT-1:0] o_ir,
  output logic [MEMADDRBIT-1:0] o_ic
);

  typedef logic [MEMADDRBIT-1:0] addr_t;
  localparam addr_t c_ONE = addr_t'(1);

  addr_t r_ii, r_ir, r_ic, r_ikr, r_ikc;
  addr_t w_step, w_row, w_col;
  logic  w_kc_last, w_kr_last, w_ic_last, w_ir_last, w_ii_last;

  assign w_step    = addr_t'(i_step);
  assign w_row     = r_ir * w_step + r_ikr;
  assign w_col     = r_ic * w_step + r_ikc;
  assign w_kc_last = (r_ikc == i_dkc - c_ONE);
  assign w_kr_last = (r_ikr == i_dkr - c_ONE);
  assign w_ic_last = (r_ic == i_dc_out - c_ONE);
  assign w_ir_last = (r_ir == i_dr_out - c_ONE);
  assign w_ii_last = (r_ii == i_di_out - c_ONE);

  assign o_k_last     = w_kr_last && w_kc_last;
  assign o_w_last     = w_ii_last && w_ir_last && w_ic_last;
  // Kernel taps hanging off the input edge are skipped but still take their cycle
  assign o_elem_valid = (w_row < i_dr) && (w_col < i_dc) && (r_ii < i_di);
  assign o_in_addr    = i_inaddr + r_ii * i_dr * i_dc + w_row * i_dc + w_col;
  assign o_out_addr   = i_outaddr + r_ii * i_dr_out * i_dc_out + r_ir * i_dc_out + r_ic;
  assign o_ii         = r_ii;
  assign o_ir         = r_ir;
  assign o_ic         = r_ic;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ii  <= '0;
      r_ir  <= '0;
      r_ic  <= '0;
      r_ikr <= '0;
      r_ikc <= '0;
    end else if (i_clear) begin
      r_ii  <= '0;
      r_ir  <= '0;
      r_ic  <= '0;
      r_ikr <= '0;
      r_ikc <= '0;
    end else begin
      if (i_k_adv) begin
        if (w_kc_last) begin
          r_ikc <= '0;
          r_ikr <= w_kr_last ? '0 : r_ikr + c_ONE;
        end else begin
          r_ikc <= r_ikc + c_ONE;
        end
      end
      if (i_w_adv) begin
        if (w_ic_last) begin
          r_ic <= '0;
          if (w_ir_last) begin
            r_ir <= '0;
            r_ii <= w_ii_last ? '0 : r_ii + c_ONE;
          end else begin
            r_ir <= r_ir + c_ONE;
          end
        end else begin
          r_ic <= r_ic + c_ONE;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/maxpool_engine.sv
`default_nettype none
// +--------------------------------------------------------------+
// | maxpool_engine : windowed signed max-pool over a shared BRAM |
// | rev 1.0                                                      |
// +--------------------------------------------------------------+
module maxpool_engine
  import maxpool_engine_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MEMADDRBIT = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mp_start,
  input  logic                  mp_enable,
  input  logic [MEMADDRBIT-1:0] mp_dkr,
  input  logic [MEMADDRBIT-1:0] mp_dkc,
  input  logic [MEMADDRBIT-1:0] mp_dr,
  input  logic [MEMADDRBIT-1:0] mp_dc,
  input  logic [MEMADDRBIT-1:0] mp_di,
  input  logic [MEMADDRBIT-1:0] mp_dr_out,
  input  logic [MEMADDRBIT-1:0] mp_dc_out,
  input  logic [MEMADDRBIT-1:0] mp_di_out,
  input  logic [MEMADDRBIT-1:0] mp_inaddr,
  input  logic [MEMADDRBIT-1:0] mp_outaddr,
  input  logic [2:0]            mp_step,
  output logic [MEMADDRBIT-1:0] mp_memaddr,
  output logic                  mp_wea,
  output logic [WIDTH-1:0]      mp_mem_in,
  input  logic [WIDTH-1:0]      mp_mem_out,
  output logic [MEMADDRBIT-1:0] mp_ir_out,
  output logic [MEMADDRBIT-1:0] mp_ic_out,
  output logic [MEMADDRBIT-1:0] mp_ii_out,
  output logic                  mp_busy,
  output logic                  mp_picture_finish
);

  localparam logic [WIDTH-1:0] c_MAX_RESET = WIDTH'(c_MAX_INIT);

  mp_state_t             r_state, w_state_nxt;
  logic [MEMADDRBIT-1:0] r_dkr, r_dkc, r_dr, r_dc, r_di, r_dr_out, r_dc_out, r_di_out;
  logic [MEMADDRBIT-1:0] r_inaddr, r_outaddr;
  logic [2:0]            r_step;
  logic [WIDTH-1:0]      r_max;
  logic                  r_rd_pend;

  logic                  w_clear, w_k_adv, w_w_adv, w_rd_issue;
  logic                  w_k_last, w_w_last, w_elem_valid, w_cfg_zero;
  logic [MEMADDRBIT-1:0] w_in_addr, w_out_addr;

  assign w_cfg_zero = (mp_dkr == '0) || (mp_dkc == '0) || (mp_dr_out == '0) ||
                      (mp_dc_out == '0) || (mp_di_out == '0);

  maxpool_addrgen #(.MEMADDRBIT(MEMADDRBIT)) u_addrgen (
    .clk          (clk),
    .rst          (rst),
    .i_dkr        (r_dkr),
    .i_dkc        (r_dkc),
    .i_dr         (r_dr),
    .i_dc         (r_dc),
    .i_di         (r_di),
    .i_dr_out     (r_dr_out),
    .i_dc_out     (r_dc_out),
    .i_di_out     (r_di_out),
    .i_inaddr     (r_inaddr),
    .i_outaddr    (r_outaddr),
    .i_step       (r_step),
    .i_clear      (w_clear),
    .i_k_adv      (w_k_adv),
    .i_w_adv      (w_w_adv),
    .o_k_last     (w_k_last),
    .o_w_last     (w_w_last),
    .o_elem_valid (w_elem_valid),
    .o_in_addr    (w_in_addr),
    .o_out_addr   (w_out_addr),
    .o_ii         (mp_ii_out),
    .o_ir         (mp_ir_out),
    .o_ic         (mp_ic_out)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_k_adv     = 1'b0;
    w_w_adv     = 1'b0;
    w_rd_issue  = 1'b0;
    mp_wea      = 1'b0;
    mp_memaddr  = '0;
    case (r_state)
      S_IDLE: begin
        if (mp_start) begin
          w_clear     = 1'b1;
          w_state_nxt = w_cfg_zero ? S_DONE : S_RD;
        end
      end
      S_RD: begin
        if (mp_enable) begin
          w_k_adv = 1'b1;
          if (w_elem_valid) begin
            w_rd_issue = 1'b1;
            mp_memaddr = w_in_addr;
          end
          if (w_k_last) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: if (mp_enable) w_state_nxt = S_WR;
      S_WR: begin
        if (mp_enable) begin
          mp_wea      = 1'b1;
          mp_memaddr  = w_out_addr;
          w_w_adv     = 1'b1;
          w_state_nxt = w_w_last ? S_DONE : S_RD;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign mp_mem_in         = mp_wea ? r_max : '0;
  assign mp_busy           = (r_state != S_IDLE);
  assign mp_picture_finish = (r_state == S_DONE);

  // Read data lands one cycle after its address; r_rd_pend marks that cycle even under stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_rd_pend <= 1'b0;
      r_max     <= c_MAX_RESET;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_pend <= w_rd_issue;
      if (w_clear || mp_wea) begin
        r_max <= c_MAX_RESET;
      end else if (r_rd_pend && ($signed(mp_mem_out) > $signed(r_max))) begin
        r_max <= mp_mem_out;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dkr     <= '0;
      r_dkc     <= '0;
      r_dr      <= '0;
      r_dc      <= '0;
      r_di      <= '0;
      r_dr_out  <= '0;
      r_dc_out  <= '0;
      r_di_out  <= '0;
      r_inaddr  <= '0;
      r_outaddr <= '0;
      r_step    <= '0;
    end else if (r_state == S_IDLE && mp_start) begin
      r_dkr     <= mp_dkr;
      r_dkc     <= mp_dkc;
      r_dr      <= mp_dr;
      r_dc      <= mp_dc;
      r_di      <= mp_di;
      r_dr_out  <= mp_dr_out;
      r_dc_out  <= mp_dc_out;
      r_di_out  <= mp_di_out;
      r_inaddr  <= mp_inaddr;
      r_outaddr <= mp_outaddr;
      r_step    <= mp_step;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_maxpool_engine.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tb_maxpool_engine : randomized scoreboard bench              |
// | rev 1.0                                                      |
// +--------------------------------------------------------------+
module tb_maxpool_engine;

  localparam int AB = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mp_start = 1'b0;
  logic          mp_enable = 1'b1;
  logic [AB-1:0] mp_dkr, mp_dkc, mp_dr, mp_dc, mp_di, mp_dr_out, mp_dc_out, mp_di_out;
  logic [AB-1:0] mp_inaddr, mp_outaddr;
  logic [2:0]    mp_step;
  logic [AB-1:0] mp_memaddr, mp_ir_out, mp_ic_out, mp_ii_out;
  logic          mp_wea, mp_busy, mp_picture_finish;
  logic [7:0]    mp_mem_in;
  logic [7:0]    mp_mem_out = 8'h00;

  maxpool_engine #(.WIDTH(8), .MEMADDRBIT(AB)) dut (
    .clk(clk), .rst(rst), .mp_start(mp_start), .mp_enable(mp_enable),
    .mp_dkr(mp_dkr), .mp_dkc(mp_dkc), .mp_dr(mp_dr), .mp_dc(mp_dc), .mp_di(mp_di),
    .mp_dr_out(mp_dr_out), .mp_dc_out(mp_dc_out), .mp_di_out(mp_di_out),
    .mp_inaddr(mp_inaddr), .mp_outaddr(mp_outaddr), .mp_step(mp_step),
    .mp_memaddr(mp_memaddr), .mp_wea(mp_wea), .mp_mem_in(mp_mem_in),
    .mp_mem_out(mp_mem_out), .mp_ir_out(mp_ir_out), .mp_ic_out(mp_ic_out),
    .mp_ii_out(mp_ii_out), .mp_busy(mp_busy), .mp_picture_finish(mp_picture_finish)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Input image store; writes are checked by the scoreboard rather than stored
  logic [7:0] mem [0:(1<<AB)-1];
  always @(posedge clk) mp_mem_out <= mem[mp_memaddr];

  logic [24:0] exp_q[$];
  logic [24:0] mon_e;
  logic [7:0]  last_wr = 8'h00;
  int vectors = 0, miscompares = 0;
  int wr_cnt = 0, start_cyc = 0, exp_fin = 0;
  bit done_seen = 1'b0;

  task automatic chk(string name, longint act, longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (mp_wea) begin
        wr_cnt++;
        last_wr = mp_mem_in;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", longint'(mp_memaddr), longint'(mon_e[24:8]));
          chk("wr_data", longint'(mp_mem_in), longint'(mon_e[7:0]));
        end
      end
      if (mp_picture_finish) begin
        chk("finish_cycle", cyc - start_cyc, exp_fin);
        done_seen = 1'b1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_cfg(int dr, int dc, int di, int dkr, int dkc, int st,
                         int dro, int dco, int dio, int ina, int outa);
    mp_dr = AB'(dr);   mp_dc = AB'(dc);   mp_di = AB'(di);
    mp_dkr = AB'(dkr); mp_dkc = AB'(dkc); mp_step = 3'(st);
    mp_dr_out = AB'(dro); mp_dc_out = AB'(dco); mp_di_out = AB'(dio);
    mp_inaddr = AB'(ina); mp_outaddr = AB'(outa);
  endtask

  // Reference: max of each in-bounds kernel window, written in ii/ir/ic order
  task automatic build_expect();
    int dr, dc, dkr, dkc, st, dro, dco, dio, ina, outa, r, c, m, v;
    logic [AB-1:0] a, o;
    dr = int'(mp_dr); dc = int'(mp_dc); dkr = int'(mp_dkr); dkc = int'(mp_dkc);
    st = int'(mp_step); dro = int'(mp_dr_out); dco = int'(mp_dc_out);
    dio = int'(mp_di_out); ina = int'(mp_inaddr); outa = int'(mp_outaddr);
    exp_q.delete();
    if (dkr == 0 || dkc == 0 || dro == 0 || dco == 0 || dio == 0) begin
      exp_fin = 1;
      return;
    end
    for (int ii = 0; ii < dio; ii++)
      for (int ir = 0; ir < dro; ir++)
        for (int ic = 0; ic < dco; ic++) begin
          m = -128;
          for (int kr = 0; kr < dkr; kr++)
            for (int kc = 0; kc < dkc; kc++) begin
              r = ir * st + kr;
              c = ic * st + kc;
              if (r < dr && c < dc) begin
                a = AB'(ina + ii * dr * dc + r * dc + c);
                v = int'($signed(mem[a]));
                if (v > m) m = v;
              end
            end
          o = AB'(outa + ii * dro * dco + ir * dco + ic);
          exp_q.push_back({o, 8'(m)});
        end
    exp_fin = dio * dro * dco * (dkr * dkc + 2) + 1;
  endtask

  task automatic run_job(int stall_at, int repulse_at);
    int n_exp;
    build_expect();
    n_exp = exp_q.size();
    if (stall_at > 0) exp_fin += 10;
    wr_cnt = 0;
    done_seen = 1'b0;
    tick();
    mp_start = 1'b1;
    start_cyc = cyc;
    for (int i = 1; i < 5000 && !done_seen; i++) begin
      tick();
      mp_start = (i == repulse_at);
      if (i == stall_at) mp_enable = 1'b0;
      if (stall_at > 0 && i == stall_at + 10) mp_enable = 1'b1;
    end
    mp_start = 1'b0;
    mp_enable = 1'b1;
    if (!done_seen) chk("finish_timeout", 0, 1);
    chk("write_count", wr_cnt, n_exp);
    tick();
    chk("busy_after_done", mp_busy, 0);
    chk("finish_one_cycle", mp_picture_finish, 0);
  endtask

  task automatic reset_mid_run();
    build_expect();
    wr_cnt = 0;
    done_seen = 1'b0;
    tick();
    mp_start = 1'b1;
    start_cyc = cyc;
    tick();
    mp_start = 1'b0;
    for (int i = 0; i < 3000 && wr_cnt < 100; i++) tick();
    chk("rst_reached_write100", wr_cnt, 100);
    chk("rst_wea_before", mp_wea, 1);
    rst = 1'b0;
    #1;
    chk("rst_memaddr", mp_memaddr, 0);
    chk("rst_wea", mp_wea, 0);
    chk("rst_mem_in", mp_mem_in, 0);
    chk("rst_busy", mp_busy, 0);
    chk("rst_finish", mp_picture_finish, 0);
    chk("rst_coords", {mp_ii_out, mp_ir_out, mp_ic_out}, 0);
    tick();
    tick();
    exp_q.delete();
    rst = 1'b1;
    chk("rst_no_finish", done_seen, 0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AB); i++) mem[i] = 8'($urandom);
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("reset_memaddr", mp_memaddr, 0);
    chk("reset_wea", mp_wea, 0);
    chk("reset_mem_in", mp_mem_in, 0);
    chk("reset_busy", mp_busy, 0);
    chk("reset_finish", mp_picture_finish, 0);
    chk("reset_coords", {mp_ii_out, mp_ir_out, mp_ic_out}, 0);
    rst = 1'b1;
    tick();
    chk("idle_busy", mp_busy, 0);

    set_cfg(12, 12, 8, 2, 2, 2, 6, 6, 8, 1061, 2213);
    run_job(0, 0);
    run_job(3, 0);
    run_job(0, 50);

    mem[500] = 8'hFB; mem[501] = 8'hFD; mem[502] = 8'h80; mem[503] = 8'hF9;
    set_cfg(2, 2, 1, 2, 2, 2, 1, 1, 1, 500, 600);
    run_job(0, 0);
    chk("window_max_value", last_wr, 8'hFD);

    mem[3024] = 8'h9C;
    set_cfg(5, 5, 1, 2, 2, 2, 3, 3, 1, 3000, 4000);
    run_job(0, 0);
    chk("edge_window_value", last_wr, 8'h9C);

    set_cfg(12, 12, 8, 0, 2, 2, 6, 6, 8, 1061, 2213);
    run_job(0, 0);
    set_cfg(12, 12, 8, 2, 2, 2, 6, 0, 8, 1061, 2213);
    run_job(0, 0);

    set_cfg(12, 12, 8, 2, 2, 2, 6, 6, 8, 1061, 2213);
    reset_mid_run();
    run_job(0, 0);

    repeat (5) begin
      set_cfg($urandom_range(9, 3), $urandom_range(9, 3), 3,
              $urandom_range(3, 1), $urandom_range(3, 1), $urandom_range(3, 1),
              $urandom_range(4, 1), $urandom_range(4, 1), $urandom_range(3, 1),
              $urandom_range(60000, 0), $urandom_range(120000, 80000));
      run_job(($urandom_range(1, 0) == 1) ? 2 : 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
